// File: rtl/alu_pkg.sv
// Shared types and constants for the round-robin ALU arbiter and its ALU.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;
  localparam int unsigned OP_W      = 4;
  localparam int unsigned SHAMT_W   = $clog2(ALU_WIDTH);

  typedef enum logic [OP_W-1:0] {
    ALU_ADD = 4'b0000,
    ALU_AND = 4'b0001,
    ALU_OR  = 4'b0010,
    ALU_SLL = 4'b0011,
    ALU_SLT = 4'b0100,
    ALU_SRL = 4'b0101,
    ALU_SUB = 4'b0110,
    ALU_XOR = 4'b0111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Operands captured from the granted requester
  typedef struct packed {
    logic [OP_W-1:0]      op;
    logic [ALU_WIDTH-1:0] a;
    logic [ALU_WIDTH-1:0] b;
  } alu_req_t;

  // Shift amounts of ALU_WIDTH or more shift every bit out
  function automatic logic shift_oob(input logic [ALU_WIDTH-1:0] amt);
    return |amt[ALU_WIDTH-1:SHAMT_W];
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU; undefined op codes produce zero.
module alu_arbiter_alu
  import alu_pkg::*;
(
  input  logic [ALU_WIDTH-1:0] a,
  input  logic [ALU_WIDTH-1:0] b,
  input  logic [OP_W-1:0]      op,
  output logic [ALU_WIDTH-1:0] result_c,
  output logic                 zero_c
);

  always_comb begin
    result_c = '0;
    case (op)
      ALU_ADD: result_c = a + b;
      ALU_AND: result_c = a & b;
      ALU_OR:  result_c = a | b;
      ALU_SLL: result_c = shift_oob(b) ? '0 : (a << b[SHAMT_W-1:0]);
      ALU_SLT: result_c = ALU_WIDTH'(a < b);
      ALU_SRL: result_c = shift_oob(b) ? '0 : (a >> b[SHAMT_W-1:0]);
      ALU_SUB: result_c = a - b;
      ALU_XOR: result_c = a ^ b;
      default: result_c = '0;
    endcase
  end

  assign zero_c = (result_c == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between N_REQ requesters; one op in flight,
// result held on a shared bus until the owning requester accepts it.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*WIDTH-1:0]     req_a,
  input  logic [N_REQ*WIDTH-1:0]     req_b,
  input  logic [N_REQ*OP_W-1:0]      req_op,
  output logic [N_REQ-1:0]           rsp_valid,
  input  logic [N_REQ-1:0]           rsp_ready,
  output logic [WIDTH-1:0]           rsp_result,
  output logic                       rsp_zero,
  output logic [$clog2(N_REQ)-1:0]   grant_id
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  arb_state_t       state_q,      state_d;
  logic [IDX_W-1:0] rr_ptr_q,     rr_ptr_d;
  logic [IDX_W-1:0] grant_id_q,   grant_id_d;
  alu_req_t         opnd_q,       opnd_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zero_q,   rsp_zero_d;
  logic [N_REQ-1:0] rsp_valid_q,  rsp_valid_d;
  logic [N_REQ-1:0] req_ready_c;
  logic [IDX_W-1:0] winner_c;
  logic [ALU_WIDTH-1:0] alu_result_c;
  logic                 alu_zero_c;

  // First valid index at or above ptr, else the lowest valid index (wrap-around)
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] hi_idx, any_idx;
    logic             hi_found, any_found;
    hi_idx    = '0;
    any_idx   = '0;
    hi_found  = 1'b0;
    any_found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (valid[i]) begin
        if (!any_found) begin
          any_idx   = IDX_W'(i);
          any_found = 1'b1;
        end
        if (!hi_found && (i >= 32'(ptr))) begin
          hi_idx   = IDX_W'(i);
          hi_found = 1'b1;
        end
      end
    end
    return hi_found ? hi_idx : any_idx;
  endfunction

  assign winner_c = rr_pick(req_valid, rr_ptr_q);

  // Next-state, operand capture and handshake decode
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_id_d   = grant_id_q;
    opnd_d       = opnd_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_valid_d  = rsp_valid_q;
    req_ready_c  = '0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          for (int unsigned i = 0; i < N_REQ; i++) begin
            if (IDX_W'(i) == winner_c) begin
              req_ready_c[i] = 1'b1;
              opnd_d.a       = req_a[i*WIDTH +: WIDTH];
              opnd_d.b       = req_b[i*WIDTH +: WIDTH];
              opnd_d.op      = req_op[i*OP_W +: OP_W];
            end
          end
          grant_id_d = winner_c;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        rsp_result_d = alu_result_c;
        rsp_zero_d   = alu_zero_c;
        for (int unsigned i = 0; i < N_REQ; i++) begin
          rsp_valid_d[i] = (IDX_W'(i) == grant_id_q);
        end
        state_d = RESP;
      end
      RESP: begin
        // rsp_valid_q is one-hot on the owner, so foreign rsp_ready bits mask off
        if (|(rsp_ready & rsp_valid_q)) begin
          rsp_valid_d = '0;
          rr_ptr_d    = (grant_id_q == IDX_W'(N_REQ - 1)) ? '0 : grant_id_q + IDX_W'(1);
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = '0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_id_q   <= '0;
      opnd_q       <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_valid_q  <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_id_q   <= grant_id_d;
      opnd_q       <= opnd_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  alu_arbiter_alu u_alu (
    .a        (opnd_q.a),
    .b        (opnd_q.b),
    .op       (opnd_q.op),
    .result_c (alu_result_c),
    .zero_c   (alu_zero_c)
  );

  assign req_ready  = req_ready_c;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_alu_arbiter;

  localparam int unsigned N = 2;
  localparam int unsigned W = 32;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N*4-1:0] req_op;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready;
  logic [W-1:0]   rsp_result;
  logic           rsp_zero;
  logic           grant_id;

  logic [31:0] ta [N];
  logic [31:0] tb [N];
  logic [3:0]  top[N];

  int n_checks = 0;
  int n_err    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = ta[i];
      req_b[i*W +: W] = tb[i];
      req_op[i*4 +: 4] = top[i];
    end
  end

  alu_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .grant_id   (grant_id)
  );

  typedef struct {
    string       name;
    int          id;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference ALU from plain integer arithmetic; returns {zero, result}
  function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint ua, ub, r;
    ua = longint'(a);
    ub = longint'(b);
    case (op)
      4'd0: r = ua + ub;
      4'd1: r = ua & ub;
      4'd2: r = ua | ub;
      4'd3: r = (ub >= 32) ? 0 : ua * (longint'(1) << ub);
      4'd4: r = (ua < ub) ? 1 : 0;
      4'd5: r = (ub >= 32) ? 0 : ua / (longint'(1) << ub);
      4'd6: r = ua - ub + 64'h1_0000_0000;
      4'd7: r = ua ^ ub;
      default: r = 0;
    endcase
    r = r % 64'h1_0000_0000;
    return {r == 0, 32'(r)};
  endfunction

  // One complete transaction on a single requester with cycle-exact checks
  task automatic do_op(input vec_t v);
    ta[v.id] = v.a; tb[v.id] = v.b; top[v.id] = v.op;
    req_valid = N'(1 << v.id);
    #1;
    chk({v.name, "_accept_ready"}, 32'(req_ready), 32'(1 << v.id));
    tick();
    req_valid = '0;
    #1;
    chk({v.name, "_exec_valid"}, 32'(rsp_valid), 32'd0);
    chk({v.name, "_exec_grant"}, 32'(grant_id), 32'(v.id));
    tick();
    chk({v.name, "_rsp_valid"}, 32'(rsp_valid), 32'(1 << v.id));
    chk({v.name, "_result"}, rsp_result, v.res);
    chk({v.name, "_zero"}, 32'(rsp_zero), 32'(v.zero));
    rsp_ready = N'(1 << v.id);
    tick();
    rsp_ready = '0;
    #1;
    chk({v.name, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{"sub_5_3",    0, 4'b0110, 32'd5,        32'd3,        32'd2,        1'b0};
    vecs[1]  = '{"add_wrap",   1, 4'b0000, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1};
    vecs[2]  = '{"slt_uns",    0, 4'b0100, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1};
    vecs[3]  = '{"op_1111",    1, 4'b1111, 32'd12,       32'd34,       32'd0,        1'b1};
    vecs[4]  = '{"slt_true",   0, 4'b0100, 32'd1,        32'hFFFFFFFF, 32'd1,        1'b0};
    vecs[5]  = '{"sll_31",     1, 4'b0011, 32'd1,        32'd31,       32'h80000000, 1'b0};
    vecs[6]  = '{"sll_32",     0, 4'b0011, 32'd1,        32'd32,       32'd0,        1'b1};
    vecs[7]  = '{"srl_31",     1, 4'b0101, 32'h80000000, 32'd31,       32'd1,        1'b0};
    vecs[8]  = '{"srl_big",    0, 4'b0101, 32'hFFFFFFFF, 32'd100,      32'd0,        1'b1};
    vecs[9]  = '{"and",        1, 4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
    vecs[10] = '{"or",         0, 4'b0010, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0};
    vecs[11] = '{"sub_neg",    1, 4'b0110, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0};
    vecs[12] = '{"op_1000",    0, 4'b1000, 32'd5,        32'd5,        32'd0,        1'b1};
    vecs[13] = '{"xor",        1, 4'b0111, 32'h12345678, 32'hFFFFFFFF, 32'hEDCBA987, 1'b0};

    rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
    for (int i = 0; i < N; i++) begin ta[i] = '0; tb[i] = '0; top[i] = '0; end
    #2;
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_result", rsp_result, 32'd0);
    chk("reset_zero", 32'(rsp_zero), 32'd0);
    chk("reset_grant", 32'(grant_id), 32'd0);
    #10 rst_n = 1'b1;
    tick();

    for (int k = 0; k < 14; k++) do_op(vecs[k]);

    // Reset while an operation is executing
    ta[1] = 32'd10; tb[1] = 32'd20; top[1] = 4'b0000;
    req_valid = 2'b10;
    #1;
    chk("rst_pre_ready", 32'(req_ready), 32'd2);
    tick();
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req_ready", 32'(req_ready), 32'd0);
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mid_result", rsp_result, 32'd0);
    chk("rst_mid_zero", 32'(rsp_zero), 32'd0);
    chk("rst_mid_grant", 32'(grant_id), 32'd0);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
    end

    // Contention: both requesters always valid, strict alternation from index 0
    ta[0] = 32'd7; tb[0] = 32'd7;  top[0] = 4'b0110;
    ta[1] = 32'd1; tb[1] = 32'd31; top[1] = 4'b0011;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      int w;
      w = k % 2;
      #1;
      chk("cont_ready", 32'(req_ready), 32'(1 << w));
      tick();
      chk("cont_grant", 32'(grant_id), 32'(w));
      chk("cont_exec_ready", 32'(req_ready), 32'd0);
      tick();
      chk("cont_rsp_valid", 32'(rsp_valid), 32'(1 << w));
      chk("cont_result", rsp_result, (w == 1) ? 32'h80000000 : 32'd0);
      chk("cont_zero", 32'(rsp_zero), (w == 1) ? 32'd0 : 32'd1);
      chk("cont_resp_ready", 32'(req_ready), 32'd0);
      rsp_ready = N'(1 << w);
      tick();
      rsp_ready = '0;
      chk("cont_rsp_drop", 32'(rsp_valid), 32'd0);
    end
    req_valid = '0;

    // Stall: requester 1 holds off its response while requester 0 waits
    ta[1] = 32'hF0F0F0F0; tb[1] = 32'hFF00FF00; top[1] = 4'b0001;
    req_valid = 2'b10;
    #1;
    chk("stall_accept", 32'(req_ready), 32'd2);
    tick();
    ta[0] = 32'd100; tb[0] = 32'd23; top[0] = 4'b0000;
    req_valid = 2'b01;
    rsp_ready = 2'b01;
    tick();
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd2);
      chk("stall_result", rsp_result, 32'hF000F000);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 2'b10;
    tick();
    rsp_ready = '0;
    #1;
    chk("stall_release_valid", 32'(rsp_valid), 32'd0);
    chk("stall_next_winner", 32'(req_ready), 32'd1);
    tick();
    req_valid = '0;
    tick();
    chk("stall_req0_valid", 32'(rsp_valid), 32'd1);
    chk("stall_req0_result", rsp_result, 32'd123);
    rsp_ready = 2'b01;
    tick();
    rsp_ready = '0;

    // Randomized traffic against the transaction-level model
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    begin
      bit          pend[N];
      logic [31:0] pa[N], pb[N];
      logic [3:0]  pop[N];
      int          skip[N];
      bit          busy;
      int          age, owner, ptr, issued, accepted, completed, cyc;
      logic [32:0] exp;
      bit          drained;
      busy = 0; age = 0; owner = 0; ptr = 0;
      issued = 0; accepted = 0; completed = 0; drained = 0;
      for (int i = 0; i < N; i++) begin pend[i] = 0; skip[i] = 0; end
      for (cyc = 0; cyc < 3200; cyc++) begin
        bit draining;
        draining = (cyc >= 3000);
        if (draining && !busy) begin
          bit any;
          any = 0;
          for (int i = 0; i < N; i++) any |= pend[i];
          if (!any) begin drained = 1; break; end
        end
        for (int i = 0; i < N; i++) begin
          if (!pend[i] && !draining && ($urandom_range(0, 2) == 0)) begin
            pend[i] = 1;
            pa[i]   = $urandom;
            pb[i]   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            pop[i]  = 4'($urandom);
            issued++;
          end
          req_valid[i] = pend[i];
          ta[i] = pa[i]; tb[i] = pb[i]; top[i] = pop[i];
        end
        rsp_ready = draining ? '1 : N'($urandom);
        #1;
        if (!busy) begin
          chk("rnd_idle_rsp_valid", 32'(rsp_valid), 32'd0);
          begin
            int w;
            w = -1;
            for (int k = 0; k < N; k++) begin
              int idx;
              idx = (ptr + k) % N;
              if (w < 0 && pend[idx]) w = idx;
            end
            if (w >= 0) begin
              chk("rnd_grant", 32'(req_ready), 32'(1 << w));
              chk("rnd_starve", 32'(skip[w] <= N - 1), 32'd1);
              skip[w] = 0;
              for (int j = 0; j < N; j++) if (j != w && pend[j]) skip[j]++;
              exp   = ref_alu(pop[w], pa[w], pb[w]);
              pend[w] = 0;
              busy  = 1;
              age   = 0;
              owner = w;
              accepted++;
            end else begin
              chk("rnd_no_grant", 32'(req_ready), 32'd0);
            end
          end
        end else begin
          age++;
          chk("rnd_busy_ready", 32'(req_ready), 32'd0);
          if (age == 1) begin
            chk("rnd_exec_valid", 32'(rsp_valid), 32'd0);
          end else begin
            chk("rnd_rsp_valid", 32'(rsp_valid), 32'(1 << owner));
            chk("rnd_result", rsp_result, exp[31:0]);
            chk("rnd_zero", 32'(rsp_zero), 32'(exp[32]));
            if (rsp_ready[owner]) begin
              busy = 0;
              ptr  = (owner + 1) % N;
              completed++;
            end
          end
        end
        tick();
      end
      rsp_ready = '0;
      req_valid = '0;
      chk("rnd_drained", 32'(drained), 32'd1);
      chk("rnd_no_drops", 32'(completed), 32'(accepted));
      chk("rnd_all_served", 32'(accepted), 32'(issued));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
